dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port data-memory arbiter between the CPU pipeline's MEM stage and a debug/loader port. It grants exactly one requester per cycle and stalls the pipeline when the CPU loses arbitration. It bounds debug starvation with a wait counter and supports a debug halt mode that freezes the CPU. It sits between the CPU's MEM stage and `Data_Memory`; the memory has combinational read and writes on the rising edge.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 4, number of consecutive lost-conflict cycles after which debug is forced to win (legal range 1..15).

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `cpu_req_i`  in  1  MEM-stage access request (load or store).
- `cpu_we_i`  in  1  CPU write enable.
- `cpu_addr_i`  in  ADDR_W  CPU address.
- `cpu_wdata_i`  in  DATA_W  CPU store data.
- `cpu_rdata_o`  out  DATA_W  CPU load data, combinational.
- `cpu_stall_o`  out  1  freeze PC and pipeline registers this cycle.
- `dbg_req_i`  in  1  debug access request; held until granted.
- `dbg_we_i`  in  1  debug write enable.
- `dbg_addr_i`  in  ADDR_W  debug address.
- `dbg_wdata_i`  in  DATA_W  debug write data.
- `dbg_halt_i`  in  1  request CPU halt.
- `dbg_gnt_o`  out  1  debug access performed this cycle.
- `dbg_rvalid_o`  out  1  registered read data valid.
- `dbg_rdata_o`  out  DATA_W  registered debug read data.
- `halted_o`  out  1  arbiter is in HALT.
- `stall_cnt_o`  out  32  saturating count of arbitration-stall cycles.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_wdata_o`  out  DATA_W  memory write data.
- `mem_rdata_i`  in  DATA_W  memory read data (combinational).

## Operation
- FSM has two states:
  - RUN (reset state).
  - HALT.
  - RUN -> HALT on an edge with `dbg_halt_i`=1.
  - HALT -> RUN on an edge with `dbg_halt_i`=0.
  - `halted_o` = (state == HALT).
- Grant in RUN:
  - CPU wins by default.
  - Debug wins if `dbg_req_i` and (!`cpu_req_i` or `wait_cnt` == `MAX_WAIT`).
- Grant in HALT:
  - Debug wins whenever `dbg_req_i`=1.
  - `cpu_stall_o`=1 unconditionally.
- `cpu_stall_o` in RUN = `cpu_req_i` & `dbg_gnt_o`.
- `wait_cnt` (4 bit):
  - Increments on each edge where `dbg_req_i` & !`dbg_gnt_o`.
  - Clears on each edge where `dbg_gnt_o`=1.
  - Never exceeds `MAX_WAIT`.
- Memory mux:
  - Granted requester drives `mem_addr_o` and `mem_wdata_o`.
  - `mem_we_o` = granted requester's write enable.
  - With no grant, `mem_we_o`=0 and `mem_addr_o` = `cpu_addr_i`.
- `cpu_rdata_o` = `mem_rdata_i` (valid only when CPU is granted).
- Debug read, granted with `dbg_we_i`=0: `dbg_rdata_o` <= `mem_rdata_i` and `dbg_rvalid_o` <= 1 at that edge. Otherwise `dbg_rvalid_o` <= 0 and `dbg_rdata_o` holds its value.
- `stall_cnt_o` increments on each edge where `cpu_stall_o`=1; it saturates at 0xFFFFFFFF.
- `mem_we_o` is forced to 0 while `rst_i`=1.

## Timing
- Reset values of registered state and outputs: state RUN, `wait_cnt` 0, `dbg_rvalid_o` 0, `dbg_rdata_o` 0, `stall_cnt_o` 0, `halted_o` 0.
- Reset values of combinational outputs with all inputs low: `cpu_stall_o` 0, `dbg_gnt_o` 0, `mem_we_o` 0.
- Grant, stall and memory-mux outputs are combinational on the current cycle's inputs and state, with zero latency.
- Writes commit at the end of the grant cycle; debug read data appears one cycle after grant.
- The stalled CPU holds `cpu_req_i` and its fields stable; it retries next cycle and is granted then, because `wait_cnt` clears.
- Halt entry: the cycle in which `dbg_halt_i` rises is arbitrated as RUN, and HALT begins the following cycle.
- Halt exit: the first RUN cycle follows the edge that samples `dbg_halt_i`=0.
- `dbg_halt_i` toggling every cycle alternates state each edge; there is no hysteresis.
- Asynchronous reset mid-access: any in-flight write is dropped and `dbg_rvalid_o` clears immediately.

## Test plan
- Only CPU requests, store 0x5 to 0x04, then load 0x04 -> `cpu_stall_o`=0 both cycles; load returns 5; `stall_cnt_o`=0.
- Only debug reads 0x00 holding 0x5 -> `dbg_gnt_o`=1 in cycle N; `dbg_rvalid_o`=1 and `dbg_rdata_o`=5 in N+1.
- CPU requests every cycle, debug requests continuously, `MAX_WAIT`=4 -> debug granted on the 5th cycle; `cpu_stall_o`=1 that cycle only; `stall_cnt_o`=1; pattern repeats every 5 cycles.
- `dbg_halt_i`=1 with CPU requesting -> next cycle `halted_o`=1, `cpu_stall_o`=1 every cycle. Debug write 0xAB to 0x10 succeeds, and `stall_cnt_o` increments each HALT cycle. After deassert, `halted_o`=0 one edge later.
- Assert `rst_i` mid-cycle during a debug write grant -> `mem_we_o`=0 immediately; memory unchanged; all registered outputs at reset values.
- Run `stall_cnt_o` preloaded (forced) to 0xFFFFFFFE with three stall cycles -> value reads 0xFFFFFFFF and holds there.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a debug/loader port.
// Debug starvation is bounded by a wait counter; a debug halt mode freezes the CPU.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_halt_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              halted_o,
  output logic [31:0]       stall_cnt_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              dbg_gnt_s, cpu_gnt_s, cpu_stall_s, mem_we_s;

  // Arbitration and next-state; halt mode is entered/left purely on the sampled halt level.
  always_comb begin
    dbg_gnt_s   = 1'b0;
    cpu_gnt_s   = 1'b0;
    cpu_stall_s = 1'b0;
    state_d     = state_q;
    case (state_q)
      ST_RUN: begin
        dbg_gnt_s   = dbg_req_i & (~cpu_req_i | (wait_cnt_q == MaxWait));
        cpu_gnt_s   = cpu_req_i & ~dbg_gnt_s;
        cpu_stall_s = cpu_req_i & dbg_gnt_s;
        state_d     = dbg_halt_i ? ST_HALT : ST_RUN;
      end
      ST_HALT: begin
        dbg_gnt_s   = dbg_req_i;
        cpu_stall_s = 1'b1;
        state_d     = dbg_halt_i ? ST_HALT : ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Memory mux; an idle port still presents the CPU address so loads see stable data.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    if (dbg_gnt_s) begin
      mem_we_s    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end else if (cpu_gnt_s) begin
      mem_we_s    = cpu_we_i;
    end else begin
      mem_we_s    = 1'b0;
    end
    mem_we_o = rst_i ? 1'b0 : mem_we_s;
  end

  // Wait counter, debug read capture and saturating stall counter.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    stall_cnt_d  = stall_cnt_q;
    if (dbg_gnt_s) begin
      wait_cnt_d = 4'd0;
    end else if (dbg_req_i && (wait_cnt_q != MaxWait)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    if (dbg_gnt_s && !dbg_we_i) begin
      dbg_rvalid_d = 1'b1;
      dbg_rdata_d  = mem_rdata_i;
    end else begin
      dbg_rvalid_d = 1'b0;
    end
    if (cpu_stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      wait_cnt_q   <= 4'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign cpu_rdata_o  = mem_rdata_i;
  assign cpu_stall_o  = cpu_stall_s;
  assign dbg_gnt_o    = dbg_gnt_s;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign halted_o     = (state_q == ST_HALT);
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural model plus directed literal pins,
// a 16-word data memory, and randomized traffic.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i, dbg_halt_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i;
  logic [31:0] cpu_rdata_o, dbg_rdata_o, stall_cnt_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        cpu_stall_o, dbg_gnt_o, dbg_rvalid_o, halted_o, mem_we_o;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_halt_i(dbg_halt_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o), .halted_o(halted_o),
    .stall_cnt_o(stall_cnt_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory: combinational read, write on rising edge.
  logic [31:0] tb_mem [0:15] = '{default: 32'h0};
  assign mem_rdata_i = tb_mem[mem_addr_o[5:2]];
  always @(posedge clk_i) if (mem_we_o) tb_mem[mem_addr_o[5:2]] <= mem_wdata_o;

  // Behavioural model state.
  logic [31:0] m_mem [0:15] = '{default: 32'h0};
  bit          m_halted, m_rvalid;
  int          m_lost;
  logic [31:0] m_rdata, m_stall;
  int          preload_seq = 0;
  int          seen_seq = 0;

  function automatic bit e_dgnt();
    return dbg_req_i && (m_halted || !cpu_req_i || m_lost >= MAX_WAIT);
  endfunction
  function automatic bit e_cgnt();
    return !m_halted && cpu_req_i && !e_dgnt();
  endfunction
  function automatic bit e_stall();
    return m_halted || (cpu_req_i && e_dgnt());
  endfunction
  function automatic bit e_we();
    if (rst_i) return 1'b0;
    if (e_dgnt()) return dbg_we_i;
    if (e_cgnt()) return cpu_we_i;
    return 1'b0;
  endfunction
  function automatic logic [31:0] e_addr();
    return e_dgnt() ? dbg_addr_i : cpu_addr_i;
  endfunction
  function automatic logic [31:0] e_wdata();
    return e_dgnt() ? dbg_wdata_i : cpu_wdata_i;
  endfunction
  function automatic logic [3:0] e_idx();
    logic [31:0] a;
    a = e_addr();
    return a[5:2];
  endfunction
  function automatic logic [31:0] sat_inc(logic [31:0] v, bit inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Model update at each edge, from the rules of the arbiter.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_halted <= 1'b0;
      m_lost   <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= 32'h0;
      m_stall  <= 32'h0;
      seen_seq <= preload_seq;
    end else begin
      if (e_we()) m_mem[e_idx()] <= e_wdata();
      m_rvalid <= e_dgnt() && !dbg_we_i;
      if (e_dgnt() && !dbg_we_i) m_rdata <= m_mem[dbg_addr_i[5:2]];
      m_lost   <= e_dgnt() ? 0 : (dbg_req_i ? ((m_lost + 1 > MAX_WAIT) ? MAX_WAIT : m_lost + 1) : m_lost);
      m_stall  <= sat_inc((preload_seq != seen_seq) ? 32'hFFFF_FFFE : m_stall, e_stall());
      seen_seq <= preload_seq;
      m_halted <= dbg_halt_i;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    chk("cpu_stall", {31'h0, cpu_stall_o}, {31'h0, e_stall()});
    chk("dbg_gnt", {31'h0, dbg_gnt_o}, {31'h0, e_dgnt()});
    chk("mem_we", {31'h0, mem_we_o}, {31'h0, e_we()});
    chk("mem_addr", mem_addr_o, e_addr());
    if (e_dgnt() || e_cgnt()) chk("mem_wdata", mem_wdata_o, e_wdata());
    if (e_cgnt()) chk("cpu_rdata", cpu_rdata_o, m_mem[cpu_addr_i[5:2]]);
    chk("halted", {31'h0, halted_o}, {31'h0, m_halted});
    chk("dbg_rvalid", {31'h0, dbg_rvalid_o}, {31'h0, m_rvalid});
    chk("dbg_rdata", dbg_rdata_o, m_rdata);
    chk("stall_cnt", stall_cnt_o, m_stall);
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    model_check();
  endtask
  task automatic to_pos();
    @(posedge clk_i);
    #1;
  endtask
  task automatic cyc();
    at_neg();
    to_pos();
  endtask

  task automatic idle();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 32'h0; dbg_wdata_i = 32'h0;
  endtask
  task automatic cpu_acc(input bit we, input logic [31:0] a, input logic [31:0] d);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
  endtask
  task automatic dbg_acc(input bit we, input logic [31:0] a, input logic [31:0] d);
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
  endtask

  initial begin
    logic [31:0] saved;
    rst_i = 1'b1;
    dbg_halt_i = 1'b0;
    idle();
    // Reset state.
    @(negedge clk_i);
    model_check();
    chk("rst_stall", {31'h0, cpu_stall_o}, 32'h0);
    chk("rst_gnt", {31'h0, dbg_gnt_o}, 32'h0);
    chk("rst_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_halted", {31'h0, halted_o}, 32'h0);
    chk("rst_rvalid", {31'h0, dbg_rvalid_o}, 32'h0);
    chk("rst_stall_cnt", stall_cnt_o, 32'h0);
    to_pos();
    rst_i = 1'b0;

    // CPU-only store then load.
    cpu_acc(1'b1, 32'h04, 32'h5);
    at_neg();
    chk("cpu_st_stall", {31'h0, cpu_stall_o}, 32'h0);
    chk("cpu_st_we", {31'h0, mem_we_o}, 32'h1);
    to_pos();
    cpu_acc(1'b0, 32'h04, 32'h0);
    at_neg();
    chk("cpu_ld_stall", {31'h0, cpu_stall_o}, 32'h0);
    chk("cpu_ld_data", cpu_rdata_o, 32'h5);
    to_pos();

    // Debug-only read of 0x00 holding 5.
    cpu_acc(1'b1, 32'h00, 32'h5);
    cyc();
    idle();
    dbg_acc(1'b0, 32'h00, 32'h0);
    at_neg();
    chk("dbg_rd_gnt", {31'h0, dbg_gnt_o}, 32'h1);
    to_pos();
    idle();
    at_neg();
    chk("dbg_rd_rvalid", {31'h0, dbg_rvalid_o}, 32'h1);
    chk("dbg_rd_data", dbg_rdata_o, 32'h5);
    chk("dbg_rd_stall_cnt", stall_cnt_o, 32'h0);
    to_pos();
    cpu_acc(1'b1, 32'h20, 32'h11);
    cyc();

    // Continuous conflict: debug wins every 5th cycle.
    cpu_acc(1'b0, 32'h04, 32'h0);
    dbg_acc(1'b0, 32'h00, 32'h0);
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("conf_gnt", {31'h0, dbg_gnt_o}, (i % 5 == 4) ? 32'h1 : 32'h0);
      chk("conf_stall", {31'h0, cpu_stall_o}, (i % 5 == 4) ? 32'h1 : 32'h0);
      to_pos();
    end
    idle();
    at_neg();
    chk("conf_stall_cnt", stall_cnt_o, 32'h2);
    to_pos();

    // Halt entry, debug write while halted, exit.
    dbg_halt_i = 1'b1;
    cpu_acc(1'b0, 32'h04, 32'h0);
    at_neg();
    chk("h0_halted", {31'h0, halted_o}, 32'h0);
    chk("h0_stall", {31'h0, cpu_stall_o}, 32'h0);
    to_pos();
    dbg_acc(1'b1, 32'h10, 32'hAB);
    at_neg();
    chk("h1_halted", {31'h0, halted_o}, 32'h1);
    chk("h1_stall", {31'h0, cpu_stall_o}, 32'h1);
    chk("h1_gnt", {31'h0, dbg_gnt_o}, 32'h1);
    chk("h1_we", {31'h0, mem_we_o}, 32'h1);
    to_pos();
    dbg_req_i = 1'b0; dbg_we_i = 1'b0;
    at_neg();
    chk("h2_stall", {31'h0, cpu_stall_o}, 32'h1);
    chk("h2_stall_cnt", stall_cnt_o, 32'h3);
    to_pos();
    dbg_halt_i = 1'b0;
    at_neg();
    chk("h3_halted", {31'h0, halted_o}, 32'h1);
    chk("h3_stall_cnt", stall_cnt_o, 32'h4);
    to_pos();
    cpu_acc(1'b0, 32'h10, 32'h0);
    at_neg();
    chk("h4_halted", {31'h0, halted_o}, 32'h0);
    chk("h4_stall", {31'h0, cpu_stall_o}, 32'h0);
    chk("h4_rdata", cpu_rdata_o, 32'hAB);
    chk("h4_stall_cnt", stall_cnt_o, 32'h5);
    to_pos();

    // Asynchronous reset in the middle of a debug write grant.
    idle();
    dbg_acc(1'b0, 32'h00, 32'h0);
    cyc();
    dbg_acc(1'b1, 32'h20, 32'h77);
    at_neg();
    chk("ar_pre_rvalid", {31'h0, dbg_rvalid_o}, 32'h1);
    chk("ar_pre_we", {31'h0, mem_we_o}, 32'h1);
    saved = tb_mem[8];
    #2 rst_i = 1'b1;
    #1;
    chk("ar_we", {31'h0, mem_we_o}, 32'h0);
    chk("ar_rvalid", {31'h0, dbg_rvalid_o}, 32'h0);
    chk("ar_rdata", dbg_rdata_o, 32'h0);
    chk("ar_stall_cnt", stall_cnt_o, 32'h0);
    chk("ar_halted", {31'h0, halted_o}, 32'h0);
    model_check();
    to_pos();
    rst_i = 1'b0;
    idle();
    chk("ar_mem_kept", tb_mem[8], saved);
    chk("ar_mem_lit", tb_mem[8], 32'h11);
    cpu_acc(1'b0, 32'h20, 32'h0);
    at_neg();
    chk("ar_readback", cpu_rdata_o, 32'h11);
    to_pos();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cpu_req_i   = ($urandom_range(0, 9) < 7);
      cpu_we_i    = $urandom_range(0, 1) == 1;
      cpu_addr_i  = 32'($urandom_range(0, 15)) << 2;
      cpu_wdata_i = $urandom;
      dbg_req_i   = ($urandom_range(0, 9) < 5);
      dbg_we_i    = $urandom_range(0, 1) == 1;
      dbg_addr_i  = 32'($urandom_range(0, 15)) << 2;
      dbg_wdata_i = $urandom;
      if ($urandom_range(0, 7) == 0) dbg_halt_i = ~dbg_halt_i;
      cyc();
    end

    // Stall counter saturation from a preloaded value.
    idle();
    dbg_halt_i = 1'b1;
    cyc();
    cyc();
    at_neg();
    #2;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    preload_seq++;
    #1;
    release dut.stall_cnt_q;
    to_pos();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("sat_stall_cnt", stall_cnt_o, 32'hFFFF_FFFF);
      to_pos();
    end
    dbg_halt_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
